// File: rtl/i2s_dac_tx_if.sv
// i2s_dac_tx_if: stereo sample handshake between a sample source and the I2S transmitter
interface i2s_dac_tx_if #(parameter int DATA_W = 24);
  logic [DATA_W-1:0] l_in;
  logic [DATA_W-1:0] r_in;
  logic in_valid;
  logic in_ready;
  modport master(output l_in, output r_in, output in_valid, input in_ready);
  modport slave(input l_in, input r_in, input in_valid, output in_ready);
endinterface

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: I2S DAC transmitter, 64 bclk slots per frame, one-entry holding buffer
module i2s_dac_tx #(
  parameter int DATA_W = 24,
  parameter int BCLK_HALF = 4
) (
  input logic clk,
  input logic reset,
  i2s_dac_tx_if.slave bus,
  output logic ac_bclk,
  output logic ac_lrclk,
  output logic ac_dac_sdata,
  output logic frame_start,
  output logic underrun
);
  localparam int DW = $clog2(BCLK_HALF);
  logic [DW-1:0] div;
  logic [5:0] slot;
  logic [5:0] ns;
  logic full;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] sh_l;
  logic [DATA_W-1:0] sh_r;
  logic tc;
  logic fall;
  logic load;
  logic active;
  assign tc = div == DW'(BCLK_HALF - 1);
  assign fall = tc && ac_bclk;
  assign load = fall && slot == 6'd63;
  assign ns = slot + 6'd1;
  assign active = slot != 6'd63 && {1'b0, slot[4:0]} < 6'(DATA_W);
  assign bus.in_ready = reset || !full;
  always_ff @(posedge clk)
    if (reset) begin
      div <= '0;
      slot <= 6'd63;
      ac_bclk <= 1'b0;
      ac_lrclk <= 1'b0;
      ac_dac_sdata <= 1'b0;
      frame_start <= 1'b0;
      underrun <= 1'b0;
      full <= 1'b0;
      hold_l <= '0;
      hold_r <= '0;
      sh_l <= '0;
      sh_r <= '0;
    end else begin
      div <= tc ? '0 : div + DW'(1);
      ac_bclk <= ac_bclk ^ tc;
      frame_start <= load;
      underrun <= load && !full && !bus.in_valid;
      if (fall) begin
        slot <= ns;
        ac_lrclk <= ns[5];
        ac_dac_sdata <= active && (slot[5] ? sh_r[DATA_W-1] : sh_l[DATA_W-1]);
      end
      if (load) begin
        sh_l <= full ? hold_l : bus.in_valid ? bus.l_in : '0;
        sh_r <= full ? hold_r : bus.in_valid ? bus.r_in : '0;
        full <= 1'b0;
      end else begin
        if (fall && active && !slot[5]) sh_l <= sh_l << 1;
        if (fall && active && slot[5]) sh_r <= sh_r << 1;
        if (bus.in_valid && !full) begin
          hold_l <= bus.l_in;
          hold_r <= bus.r_in;
          full <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: directed frame-level checks of i2s_dac_tx with BCLK_HALF=2, DATA_W=24
module tb_i2s_dac_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ac_bclk;
  logic ac_lrclk;
  logic ac_dac_sdata;
  logic frame_start;
  logic underrun;
  int n_vec = 0;
  int n_err = 0;
  logic [47:0] q[$];
  i2s_dac_tx_if #(.DATA_W(24)) bus();
  i2s_dac_tx #(.DATA_W(24), .BCLK_HALF(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .ac_bclk(ac_bclk),
    .ac_lrclk(ac_lrclk),
    .ac_dac_sdata(ac_dac_sdata),
    .frame_start(frame_start),
    .underrun(underrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] exp_sd(input logic [23:0] l, input logic [23:0] r);
    logic [63:0] e;
    e = '0;
    for (int s = 1; s <= 24; s++) e[s] = l[24-s];
    for (int s = 33; s <= 56; s++) e[s] = r[56-s];
    return e;
  endfunction
  initial begin
    logic rdy;
    logic rst_s;
    bus.in_valid = 1'b0;
    bus.l_in = '0;
    bus.r_in = '0;
    rdy = 1'b0;
    rst_s = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (bus.in_valid && rdy && !rst_s) q.delete(0);
      bus.in_valid = q.size() != 0;
      if (q.size() != 0) {bus.l_in, bus.r_in} = q[0];
      rdy = bus.in_ready;
      rst_s = reset;
    end
  end
  task automatic run_frame(input int ncyc, input int push_at, input logic [47:0] pv,
                           output logic [63:0] sd, output logic [63:0] lr, output int fs_n,
                           output int ur_n, output logic ir0, output logic ir128, output logic ur0);
    sd = '0;
    lr = '0;
    fs_n = 0;
    ur_n = 0;
    ir0 = 1'b0;
    ir128 = 1'b0;
    ur0 = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (c % 4 == 0) begin
        sd[c/4] = ac_dac_sdata;
        lr[c/4] = ac_lrclk;
      end
      fs_n += int'(frame_start);
      ur_n += int'(underrun);
      if (c == 0) begin
        ir0 = bus.in_ready;
        ur0 = underrun;
      end
      if (c == 128) ir128 = bus.in_ready;
      if (c == push_at) q.push_back(pv);
      step();
    end
  endtask
  task automatic frame(input string nm, input logic [23:0] l, input logic [23:0] r, input int eur,
                       input logic eir128, input int push_at, input logic [47:0] pv);
    logic [63:0] sd;
    logic [63:0] lr;
    int fs_n;
    int ur_n;
    logic ir0;
    logic ir128;
    logic ur0;
    run_frame(256, push_at, pv, sd, lr, fs_n, ur_n, ir0, ir128, ur0);
    chk({nm, " sdata"}, sd, exp_sd(l, r));
    chk({nm, " lrclk"}, lr, {32'hFFFF_FFFF, 32'h0});
    chk({nm, " frame_start count"}, 64'(fs_n), 64'd1);
    chk({nm, " underrun count"}, 64'(ur_n), 64'(eur));
    chk({nm, " underrun at load"}, 64'(ur0), 64'(eur != 0));
    chk({nm, " in_ready after load"}, 64'(ir0), 64'd1);
    chk({nm, " in_ready mid frame"}, 64'(ir128), 64'(eir128));
  endtask
  initial begin
    logic [63:0] sd;
    logic [63:0] lr;
    int fs_n;
    int ur_n;
    logic ir0;
    logic ir128;
    logic ur0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    q.push_back({24'hA5A5A5, 24'h5A5A5A});
    for (int i = 0; i < 2; i++) step();
    chk("rst bclk", 64'(ac_bclk), 64'd0);
    chk("rst lrclk", 64'(ac_lrclk), 64'd0);
    chk("rst sdata", 64'(ac_dac_sdata), 64'd0);
    chk("rst frame_start", 64'(frame_start), 64'd0);
    chk("rst underrun", 64'(underrun), 64'd0);
    chk("rst in_ready", 64'(bus.in_ready), 64'd1);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("first frame_start @%0d", i), 64'(frame_start), 64'(i == 4));
    end
    chk("first load underrun", 64'(underrun), 64'd0);
    frame("f1", 24'hA5A5A5, 24'h5A5A5A, 0, 1'b1, -1, '0);
    q.push_back({24'h000001, 24'h000002});
    q.push_back({24'h7FFFFF, 24'h800000});
    frame("f2", 24'h0, 24'h0, 1, 1'b0, -1, '0);
    frame("f3", 24'h000001, 24'h000002, 0, 1'b0, -1, '0);
    frame("f4", 24'h7FFFFF, 24'h800000, 0, 1'b1, -1, '0);
    frame("uf5", 24'h0, 24'h0, 1, 1'b1, -1, '0);
    frame("uf6", 24'h0, 24'h0, 1, 1'b1, -1, '0);
    frame("uf7", 24'h0, 24'h0, 1, 1'b1, 255, {24'h123456, 24'h000000});
    frame("f8", 24'h123456, 24'h0, 0, 1'b1, -1, '0);
    run_frame(162, 10, {24'hFFFFFF, 24'hFFFFFF}, sd, lr, fs_n, ur_n, ir0, ir128, ur0);
    chk("slot40 lrclk", 64'(ac_lrclk), 64'd1);
    chk("slot40 in_ready", 64'(bus.in_ready), 64'd0);
    reset = 1'b1;
    step();
    chk("midrst bclk", 64'(ac_bclk), 64'd0);
    chk("midrst lrclk", 64'(ac_lrclk), 64'd0);
    chk("midrst sdata", 64'(ac_dac_sdata), 64'd0);
    chk("midrst frame_start", 64'(frame_start), 64'd0);
    chk("midrst underrun", 64'(underrun), 64'd0);
    chk("midrst in_ready", 64'(bus.in_ready), 64'd1);
    step();
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("post-rst frame_start @%0d", i), 64'(frame_start), 64'(i == 4));
    end
    frame("f10", 24'h0, 24'h0, 1, 1'b1, -1, '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
